// File: rtl/seg_scan_if.sv
// Bundle of display-side signals between user logic and the seven-segment scan controller.
// Scan handshake: load is a single-cycle strobe with no backpressure; everything else is level.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     digit_en;
    logic [6:0]                seg_in;
    logic [3:0]                nibble;
    logic [6:0]                seg_n;
    logic [NUM_DIGITS-1:0]     anode_n;
    logic                      frame_start;
    logic [1:0]                dbg_state;

    modport master (
        output enable, load, digits_in, digit_en, seg_in,
        input  nibble, seg_n, anode_n, frame_start, dbg_state
    );

    modport slave (
        input  enable, load, digits_in, digit_en, seg_in,
        output nibble, seg_n, anode_n, frame_start, dbg_state
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared external decoder.
// Double-buffered digit values; commits happen only at frame start so frames never tear.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    seg_scan_if.slave   bus
);
    localparam int MAXC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         pending_q, pending_d;
    logic [DW-1:0]         active_q, active_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  fs_q, fs_d;
    logic                  commit;
    logic                  enter_blank;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        anode_d     = '1;
        fs_d        = 1'b0;
        commit      = 1'b0;
        enter_blank = 1'b0;
        nibble_d    = nibble_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                state_d     = BLANK;
                fs_d        = 1'b1;
                commit      = 1'b1;
                enter_blank = 1'b1;
            end
            BLANK: begin
                if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    state_d        = SHOW;
                    cnt_d          = '0;
                    anode_d[idx_q] = ~bus.digit_en[idx_q];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SHOW: begin
                if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
                    state_d     = BLANK;
                    cnt_d       = '0;
                    enter_blank = 1'b1;
                    if (idx_q == IW'(NUM_DIGITS - 1)) begin
                        idx_d  = '0;
                        fs_d   = 1'b1;
                        commit = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d          = cnt_q + CW'(1);
                    anode_d[idx_q] = ~bus.digit_en[idx_q];
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable overrides everything; buffers are kept so re-enable resumes the same values.
        if (!bus.enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            idx_d       = '0;
            anode_d     = '1;
            fs_d        = 1'b0;
            commit      = 1'b0;
            enter_blank = 1'b0;
        end

        pending_d = bus.load ? bus.digits_in : pending_q;
        active_d  = commit ? pending_d : active_q;
        if (enter_blank)
            nibble_d = active_d[{idx_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= '0;
            active_q  <= '0;
            nibble_q  <= 4'h0;
            anode_q   <= '1;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            nibble_q  <= nibble_d;
            anode_q   <= anode_d;
            fs_q      <= fs_d;
        end
    end

    assign bus.nibble      = nibble_q;
    assign bus.anode_n     = anode_q;
    assign bus.frame_start = fs_q;
    assign bus.seg_n       = (&anode_q) ? 7'h7F : bus.seg_in;
    assign bus.dbg_state   = state_q;
endmodule
